wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 39 +++
 rtl/wb_stage.sv | 88 ++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Writeback-stage bundle: EX-side completion handshake, LSU response and
// register-file / forwarding / status results.
interface wb_stage_if;
  // Handshake: an instruction moves from EX into WB in exactly the cycles where
  // en_wb_i and ready_wb_o are both 1. en_wb_i may be raised whether or not
  // ready_wb_o is 1, and it does not have to stay high while ready_wb_o is 0.
  // lsu_resp_valid_i is a one-cycle pulse. It is only used while a load waits in WB.
  logic        en_wb_i;
  logic [4:0]  rf_waddr_ex_i;
  logic [31:0] rf_wdata_ex_i;
  logic        rf_we_ex_i;
  logic        lsu_load_i;
  logic        lsu_resp_valid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_err_i;
  logic        ready_wb_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        rf_we_wb_o;
  logic        fwd_valid_o;
  logic        load_pending_o;
  logic        retire_o;
  logic        load_err_o;
  logic [31:0] instret_o;

  modport master (
    output en_wb_i, rf_waddr_ex_i, rf_wdata_ex_i, rf_we_ex_i, lsu_load_i,
    output lsu_resp_valid_i, lsu_rdata_i, lsu_err_i,
    input  ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o, fwd_valid_o,
    input  load_pending_o, retire_o, load_err_o, instret_o
  );

  modport slave (
    input  en_wb_i, rf_waddr_ex_i, rf_wdata_ex_i, rf_we_ex_i, lsu_load_i,
    input  lsu_resp_valid_i, lsu_rdata_i, lsu_err_i,
    output ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o, fwd_valid_o,
    output load_pending_o, retire_o, load_err_o, instret_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: holds one completed EX instruction for a single cycle.
// A load stays here until the LSU returns its data or reports an error.
module wb_stage (
  input  logic       clk_i,
  input  logic       rst_ni,
  wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB_VALID = 2'd1,
    WB_LOAD  = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] instret_q;

  logic in_load;
  logic load_resp;
  logic load_done;
  logic load_fail;
  logic ready;
  logic accept;
  logic retire;
  logic write;

  assign in_load   = (state_q == WB_LOAD);
  // LSU responses outside WB_LOAD do not belong to any instruction held here.
  assign load_resp = in_load & bus.lsu_resp_valid_i;
  assign load_done = load_resp & ~bus.lsu_err_i;
  assign load_fail = load_resp &  bus.lsu_err_i;

  assign ready  = ~in_load | bus.lsu_resp_valid_i;
  assign accept = bus.en_wb_i & ready;
  assign retire = (state_q == WB_VALID) | load_done;
  assign write  = retire & we_q & (waddr_q != 5'd0);

  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = bus.lsu_load_i ? WB_LOAD : WB_VALID;
    end else if (in_load && !bus.lsu_resp_valid_i) begin
      state_d = WB_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        waddr_q <= bus.rf_waddr_ex_i;
        wdata_q <= bus.rf_wdata_ex_i;
        we_q    <= bus.rf_we_ex_i;
      end else if (load_done) begin
        // Keep the load data so the write port holds it while idle afterwards.
        wdata_q <= bus.lsu_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign bus.ready_wb_o     = ready;
  assign bus.rf_waddr_wb_o  = waddr_q;
  assign bus.rf_wdata_wb_o  = load_done ? bus.lsu_rdata_i : wdata_q;
  assign bus.rf_we_wb_o     = write;
  assign bus.fwd_valid_o    = write;
  assign bus.load_pending_o = in_load & ~bus.lsu_resp_valid_i;
  assign bus.retire_o       = retire;
  assign bus.load_err_o     = load_fail;
  assign bus.instret_o      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: at most one instruction sits in WB
  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        load;
  } instr_t;

  instr_t      pend_q[$];
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_instret;

  // Compare process: runs each cycle, 2 time units after inputs change at negedge
  initial begin
    instr_t cur;
    logic e_ready, e_we, e_ret, e_err, e_pend, done;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pend_q.delete();
        m_addr = 5'd0; m_data = 32'd0; m_instret = 32'd0;
        chk("rst_ready", 32'(bus.ready_wb_o), 32'd1);
        chk("rst_outs", {bus.rf_we_wb_o, bus.fwd_valid_o, bus.retire_o,
                         bus.load_err_o, bus.load_pending_o, bus.rf_waddr_wb_o}, 32'd0);
        chk("rst_data", bus.rf_wdata_wb_o, 32'd0);
        chk("rst_instret", bus.instret_o, 32'd0);
      end else begin
        e_ready = 1'b1; e_we = 1'b0; e_ret = 1'b0; e_err = 1'b0; e_pend = 1'b0; done = 1'b0;
        e_addr = m_addr; e_data = m_data;
        if (pend_q.size() != 0) begin
          cur = pend_q[0];
          e_addr = cur.waddr;
          e_data = cur.wdata;
          if (!cur.load) begin
            e_ret = 1'b1; done = 1'b1;
          end else if (bus.lsu_resp_valid_i) begin
            done = 1'b1;
            if (bus.lsu_err_i) e_err = 1'b1;
            else begin e_ret = 1'b1; e_data = bus.lsu_rdata_i; end
          end else begin
            e_ready = 1'b0; e_pend = 1'b1;
          end
          e_we = e_ret && cur.we && (cur.waddr != 5'd0);
        end
        chk("ready", 32'(bus.ready_wb_o), 32'(e_ready));
        chk("we", 32'(bus.rf_we_wb_o), 32'(e_we));
        chk("fwd_valid", 32'(bus.fwd_valid_o), 32'(e_we));
        chk("retire", 32'(bus.retire_o), 32'(e_ret));
        chk("load_err", 32'(bus.load_err_o), 32'(e_err));
        chk("load_pending", 32'(bus.load_pending_o), 32'(e_pend));
        chk("waddr", 32'(bus.rf_waddr_wb_o), 32'(e_addr));
        chk("wdata", bus.rf_wdata_wb_o, e_data);
        chk("instret", bus.instret_o, m_instret);
        if (e_ret) m_instret = m_instret + 32'd1;
        m_addr = e_addr;
        m_data = e_data;
        if (done) void'(pend_q.pop_front());
        if (bus.en_wb_i && e_ready)
          pend_q.push_back('{waddr: bus.rf_waddr_ex_i, wdata: bus.rf_wdata_ex_i,
                             we: bus.rf_we_ex_i, load: bus.lsu_load_i});
      end
    end
  end

  // Driver: one call drives the inputs for one cycle, starting at negedge
  task automatic step(input logic en, input logic [4:0] a, input logic [31:0] d,
                      input logic we, input logic ld, input logic rv,
                      input logic [31:0] rd, input logic er);
    @(negedge clk);
    bus.en_wb_i = en; bus.rf_waddr_ex_i = a; bus.rf_wdata_ex_i = d;
    bus.rf_we_ex_i = we; bus.lsu_load_i = ld;
    bus.lsu_resp_valid_i = rv; bus.lsu_rdata_i = rd; bus.lsu_err_i = er;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic op(input logic [4:0] a, input logic [31:0] d, input logic ld);
    step(1'b1, a, d, 1'b1, ld, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] rd, input logic er);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, rd, er);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en_wb_i = 1'b0; bus.rf_waddr_ex_i = 5'd0; bus.rf_wdata_ex_i = 32'd0;
    bus.rf_we_ex_i = 1'b0; bus.lsu_load_i = 1'b0; bus.lsu_resp_valid_i = 1'b0;
    bus.lsu_rdata_i = 32'd0; bus.lsu_err_i = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("lit_rst_ready", 32'(bus.ready_wb_o), 32'd1);
    rst_n = 1'b1;

    // Single non-load
    op(5'd5, 32'hDEADBEEF, 1'b0);
    #3 chk("lit_nl_ready", 32'(bus.ready_wb_o), 32'd1);
    idle();
    #3;
    chk("lit_nl_we", 32'(bus.rf_we_wb_o), 32'd1);
    chk("lit_nl_addr", 32'(bus.rf_waddr_wb_o), 32'd5);
    chk("lit_nl_data", bus.rf_wdata_wb_o, 32'hDEADBEEF);
    chk("lit_nl_retire", 32'(bus.retire_o), 32'd1);
    idle();
    #3 chk("lit_nl_instret", bus.instret_o, 32'd1);

    // Load answered three cycles after accept
    op(5'd7, 32'h0, 1'b1);
    idle();
    #3 chk("lit_ld_ready_n1", 32'(bus.ready_wb_o), 32'd0);
    chk("lit_ld_pend_n1", 32'(bus.load_pending_o), 32'd1);
    idle();
    #3 chk("lit_ld_ready_n2", 32'(bus.ready_wb_o), 32'd0);
    chk("lit_ld_pend_n2", 32'(bus.load_pending_o), 32'd1);
    resp(32'h12345678, 1'b0);
    #3 chk("lit_ld_we", 32'(bus.rf_we_wb_o), 32'd1);
    chk("lit_ld_addr", 32'(bus.rf_waddr_wb_o), 32'd7);
    chk("lit_ld_data", bus.rf_wdata_wb_o, 32'h12345678);
    chk("lit_ld_ready_n3", 32'(bus.ready_wb_o), 32'd1);
    idle();
    #3 chk("lit_ld_instret", bus.instret_o, 32'd2);

    // Errored load
    op(5'd9, 32'h0, 1'b1);
    idle();
    resp(32'hFFFF0000, 1'b1);
    #3 chk("lit_err_we", 32'(bus.rf_we_wb_o), 32'd0);
    chk("lit_err_flag", 32'(bus.load_err_o), 32'd1);
    chk("lit_err_retire", 32'(bus.retire_o), 32'd0);
    idle();
    #3 chk("lit_err_instret", bus.instret_o, 32'd2);

    // Four back-to-back non-loads, third one targets x0
    do_reset();
    op(5'd1, 32'h11, 1'b0);
    #3 chk("lit_b2b_ready0", 32'(bus.ready_wb_o), 32'd1);
    op(5'd2, 32'h22, 1'b0);
    #3 chk("lit_b2b_we1", {bus.ready_wb_o, bus.rf_we_wb_o, 3'd0, bus.rf_waddr_wb_o}, {1'b1, 1'b1, 3'd0, 5'd1});
    op(5'd0, 32'h33, 1'b0);
    #3 chk("lit_b2b_we2", {bus.ready_wb_o, bus.rf_we_wb_o, 3'd0, bus.rf_waddr_wb_o}, {1'b1, 1'b1, 3'd0, 5'd2});
    op(5'd3, 32'h44, 1'b0);
    #3 chk("lit_b2b_x0", {bus.ready_wb_o, bus.rf_we_wb_o, bus.fwd_valid_o, bus.retire_o}, 4'b1001);
    idle();
    #3 chk("lit_b2b_we4", bus.rf_wdata_wb_o, 32'h44);
    idle();
    #3 chk("lit_b2b_instret", bus.instret_o, 32'd4);

    // Load response coinciding with a new non-load accept
    op(5'd10, 32'h0, 1'b1);
    idle();
    step(1'b1, 5'd11, 32'h0000_0B0B, 1'b1, 1'b0, 1'b1, 32'hAAAA5555, 1'b0);
    #3 chk("lit_ovl_data", bus.rf_wdata_wb_o, 32'hAAAA5555);
    chk("lit_ovl_ready", 32'(bus.ready_wb_o), 32'd1);
    idle();
    #3 chk("lit_ovl_next", {bus.rf_we_wb_o, bus.rf_waddr_wb_o}, {1'b1, 5'd11});

    // Instruction counter wrap
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    m_instret = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    #2 chk("lit_wrap_preset", bus.instret_o, 32'hFFFF_FFFF);
    op(5'd1, 32'h1, 1'b0);
    idle();
    idle();
    #3 chk("lit_wrap_zero", bus.instret_o, 32'd0);

    // Reset while a load waits; the late response must not write
    op(5'd12, 32'h0, 1'b1);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #3 chk("lit_rstld_pend", 32'(bus.load_pending_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp(32'hCAFEF00D, 1'b0);
    #3 chk("lit_rstld_we", {bus.rf_we_wb_o, bus.retire_o}, 2'b00);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom(),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           $urandom(),
           ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    rst_n = 1'b1;
    idle();
    idle();
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
